canvas_pixel_streamer: RTL



---
 rtl/canvas_pixel_streamer_pkg.sv | 25 ++
 rtl/canvas_pixel_streamer_brush_decode.sv | 55 +++++
 rtl/canvas_pixel_streamer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/canvas_pixel_streamer_pkg.sv
// ============================================================================
// canvas_pkg : shared types and helpers for the canvas pixel streamer
// Rev 1.0
// ============================================================================
`default_nettype none

package canvas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEF_W = 28;
    localparam int DEF_H = 28;
    localparam int IDX_W = $clog2(DEF_W * DEF_H);

    function automatic int cell_idx(input int x, input int y, input int w);
        return y * w + x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/canvas_pixel_streamer_brush_decode.sv
// ============================================================================
// canvas_brush_decode : anchor + brush size -> per-cell set/clear masks
// Rev 1.0
// ============================================================================
`default_nettype none

module canvas_brush_decode
    import canvas_pkg::*;
#(
    parameter int W  = 28,
    parameter int H  = 28,
    parameter int XW = $clog2(W),
    parameter int YW = $clog2(H)
) (
    input  logic [XW-1:0]  x,
    input  logic [YW-1:0]  y,
    input  logic           big,
    input  logic           val,
    output logic [W*H-1:0] set_mask,
    output logic [W*H-1:0] clr_mask,
    output logic           anchor_ok
);

    logic [W-1:0] col_hit;
    logic [H-1:0] row_hit;
    logic [XW:0]  x1;
    logic [YW:0]  y1;

    // One extra bit so x+1 / y+1 never wrap back onto column/row 0.
    assign x1 = {1'b0, x} + (XW+1)'(1);
    assign y1 = {1'b0, y} + (YW+1)'(1);

    assign anchor_ok = ({1'b0, x} < (XW+1)'(W)) && ({1'b0, y} < (YW+1)'(H));

    for (genvar gx = 0; gx < W; gx++) begin : g_col
        assign col_hit[gx] = ({1'b0, x} == (XW+1)'(gx)) || (big && (x1 == (XW+1)'(gx)));
    end

    for (genvar gy = 0; gy < H; gy++) begin : g_row
        assign row_hit[gy] = ({1'b0, y} == (YW+1)'(gy)) || (big && (y1 == (YW+1)'(gy)));
    end

    for (genvar gy = 0; gy < H; gy++) begin : g_cell_y
        for (genvar gx = 0; gx < W; gx++) begin : g_cell_x
            localparam int K = cell_idx(gx, gy, W);
            logic hit;
            assign hit         = anchor_ok & col_hit[gx] & row_hit[gy];
            assign set_mask[K] = hit & val;
            assign clr_mask[K] = hit & ~val;
        end
    end

endmodule

`default_nettype wire

// File: rtl/canvas_pixel_streamer.sv
// ============================================================================
// canvas_pixel_streamer : binary drawing canvas, streamed raster-order over
// a valid/ready pixel interface.   Rev 1.0
// ============================================================================
`default_nettype none

module canvas_pixel_streamer
    import canvas_pkg::*;
#(
    parameter int               W       = 28,
    parameter int               H       = 28,
    parameter int               PIX_W   = 8,
    parameter logic [PIX_W-1:0] PIX_ON  = 8'd255,
    parameter logic [PIX_W-1:0] PIX_OFF = 8'd0,
    parameter int               XW      = $clog2(W),
    parameter int               YW      = $clog2(H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_draw_valid,
    input  logic [XW-1:0]    i_draw_x,
    input  logic [YW-1:0]    i_draw_y,
    input  logic             i_draw_val,
    input  logic             i_brush_big,
    input  logic             i_clear,
    input  logic             i_start,
    output logic [PIX_W-1:0] o_pixel,
    output logic             o_pixel_valid,
    input  logic             i_pixel_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [W*H-1:0]   o_canvas
);

    localparam int               N     = W * H;
    localparam int               CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] idx, idx_nx;
    logic [N-1:0]     canvas;
    logic [N-1:0]     set_mask, clr_mask;
    logic             anchor_ok;
    logic             xfer;
    logic             draw_en;

    canvas_brush_decode #(
        .W  (W),
        .H  (H),
        .XW (XW),
        .YW (YW)
    ) u_brush (
        .x         (i_draw_x),
        .y         (i_draw_y),
        .big       (i_brush_big),
        .val       (i_draw_val),
        .set_mask  (set_mask),
        .clr_mask  (clr_mask),
        .anchor_ok (anchor_ok)
    );

    assign xfer    = (state == STREAM) && i_pixel_ready;
    // Canvas is frozen while a frame is in flight.
    assign draw_en = i_draw_valid && anchor_ok && (state != STREAM);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                idx_nx = '0;
                if (i_start && !i_clear) state_nx = STREAM;
            end
            STREAM: begin
                if (i_clear) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else if (xfer) begin
                    if (idx == LAST) begin
                        state_nx = DONE;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            canvas <= '0;
        end else if (i_clear) begin
            canvas <= '0;
        end else if (draw_en) begin
            canvas <= (canvas & ~clr_mask) | set_mask;
        end
    end

    assign o_pixel_valid = (state == STREAM);
    assign o_busy        = (state == STREAM);
    assign o_done        = (state == DONE);
    assign o_pixel       = ((state == STREAM) && canvas[idx]) ? PIX_ON : PIX_OFF;
    assign o_canvas      = canvas;

endmodule

`default_nettype wire
